// File: rtl/csa_operand_packer.sv
// Serial-to-parallel operand packer for the multi-operand carry-save adder.
// Collects up to N W-bit words into a registered flat bus plus a reference sum.
module csa_operand_packer #(
  parameter  int N  = 9,
  parameter  int W  = 4,
  localparam int SW = W + $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [W*N-1:0]  out_data,
  output logic [SW-1:0]   out_sum,
  output logic [CW-1:0]   out_count,
  output logic            out_valid,
  input  logic            out_ready
);

  // state | meaning
  // FILL  | collecting words into slots 0..N-1
  // HOLD  | completed vector presented, waiting for out_ready
  typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam int SLW = $clog2(N);

  state_t           r_state;
  logic [SLW-1:0]   r_slot;
  logic [W*N-1:0]   r_data;
  logic [SW-1:0]    r_sum;
  logic [CW-1:0]    r_count;

  state_t           w_state_nxt;
  logic [SLW-1:0]   w_slot_nxt;
  logic [W*N-1:0]   w_data_nxt;
  logic [SW-1:0]    w_sum_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_accept;

  assign in_ready  = (r_state == ST_FILL) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_data  = r_data;
  assign out_sum   = r_sum;
  assign out_count = r_count;
  assign out_valid = (r_state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_slot  <= '0;
      r_data  <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_data  <= w_data_nxt;
      r_sum   <= w_sum_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_data_nxt  = r_data;
    w_sum_nxt   = r_sum;
    w_count_nxt = r_count;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          w_data_nxt[r_slot*W +: W] = in_data;
          w_sum_nxt   = r_sum + SW'(in_data);
          w_count_nxt = r_count + CW'(1);
          if ((r_slot == SLW'(N - 1)) || in_last) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_slot_nxt = r_slot + SLW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          // vector consumed; a word arriving now starts the next vector at slot 0
          w_state_nxt = ST_FILL;
          w_slot_nxt  = '0;
          w_data_nxt  = '0;
          w_sum_nxt   = '0;
          w_count_nxt = '0;
          if (in_valid) begin
            w_data_nxt[W-1:0] = in_data;
            w_sum_nxt   = SW'(in_data);
            w_count_nxt = CW'(1);
            if (in_last) begin
              w_state_nxt = ST_HOLD;
            end else begin
              w_slot_nxt = SLW'(1);
            end
          end
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

endmodule

// File: tb/tb_csa_operand_packer.sv
// Self-checking bench for csa_operand_packer (N=9, W=4) with a vector scoreboard.
module tb_csa_operand_packer;

  localparam int N  = 9;
  localparam int W  = 4;
  localparam int SW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [W*N-1:0]  out_data;
  logic [SW-1:0]   out_sum;
  logic [CW-1:0]   out_count;
  logic            out_valid;
  logic            out_ready = 1'b0;

  csa_operand_packer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W*N-1:0] d;
    logic [SW-1:0]  s;
    logic [CW-1:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model: tracks accepted words and pushes each completed vector
  logic            m_hold = 1'b0;
  logic [W*N-1:0]  m_vec = '0;
  int              m_sum = 0;
  int              m_cnt = 0;
  int              words_in = 0;
  int              words_out = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_vec  = '0;
      m_sum  = 0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      logic acc;
      acc = in_valid && (!m_hold || out_ready);
      if (m_hold && out_ready) begin
        m_hold = 1'b0;
        m_vec  = '0;
        m_sum  = 0;
        m_cnt  = 0;
      end
      if (acc) begin
        m_vec[m_cnt*W +: W] = in_data;
        m_sum = m_sum + int'(in_data);
        m_cnt = m_cnt + 1;
        words_in = words_in + 1;
        if (m_cnt == N || in_last) begin
          exp_q.push_back({m_vec, SW'(m_sum), CW'(m_cnt)});
          m_hold = 1'b1;
        end
      end
    end
  end

  // scoreboard: every cycle checks handshake signals and the held vector
  always @(negedge clk) begin
    if (rst_n) begin
      logic m_ready;
      m_ready = !m_hold || out_ready;
      n_cmp++;
      if (out_valid !== m_hold) begin
        n_err++;
        $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, m_hold, $time);
      end
      n_cmp++;
      if (in_ready !== m_ready) begin
        n_err++;
        $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, m_ready, $time);
      end
      if (m_hold) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_queue: got empty want 1 entry at %0t", $time);
        end else if (out_data !== exp_q[0].d || out_sum !== exp_q[0].s || out_count !== exp_q[0].c) begin
          n_err++;
          $display("FAIL sb_vector: got d=%h s=%0d c=%0d want d=%h s=%0d c=%0d at %0t",
                   out_data, out_sum, out_count, exp_q[0].d, exp_q[0].s, exp_q[0].c, $time);
        end
        if (out_ready && exp_q.size() != 0) begin
          int slot_sum;
          logic [W*N-1:0] dv;
          slot_sum = 0;
          dv = out_data;
          for (int k = 0; k < N; k++) slot_sum += int'(dv[k*W +: W]);
          n_cmp++;
          if (int'(out_sum) !== slot_sum) begin
            n_err++;
            $display("FAIL sb_adder_sum: got %0d want %0d at %0t", out_sum, slot_sum, $time);
          end
          words_out = words_out + int'(exp_q[0].c);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sum !== '0 || out_count !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d c=%0d want all 0",
               out_valid, out_data, out_sum, out_count);
    end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_vector();
    out_ready = 1'b0;
    for (int i = 1; i <= N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      in_last  = 1'b0;
      if (i == N) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL full_early_valid: got %b want 0", out_valid);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 36'h987654321 || out_sum !== 8'd45 ||
        out_count !== 4'd9 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_vector: got v=%b d=%h s=%0d c=%0d r=%b want v=1 d=987654321 s=45 c=9 r=0",
               out_valid, out_data, out_sum, out_count, in_ready);
    end
    drain();
  endtask

  task automatic test_short_vector();
    logic [W-1:0] words [3];
    logic [W*N-1:0] dv;
    words[0] = 4'hF; words[1] = 4'hF; words[2] = 4'h7;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 36'h0000007FF || out_sum !== 8'd37 || out_count !== 4'd3) begin
      n_err++;
      $display("FAIL short_vector: got v=%b d=%h s=%0d c=%0d want v=1 d=0000007ff s=37 c=3",
               out_valid, out_data, out_sum, out_count);
    end
    dv = out_data;
    for (int k = 3; k < N; k++) begin
      n_cmp++;
      if (dv[k*W +: W] !== 4'h0) begin
        n_err++;
        $display("FAIL short_pad_slot%0d: got %h want 0", k, dv[k*W +: W]);
      end
    end
    drain();
  endtask

  task automatic test_max_value();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 4'hF;
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_sum !== 8'h87 || out_data !== 36'hFFFFFFFFF || out_count !== 4'd9) begin
      n_err++;
      $display("FAIL max_value: got d=%h s=%0d c=%0d want d=fffffffff s=135 c=9",
               out_data, out_sum, out_count);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 2 * N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      in_last  = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready word%0d: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      if (i == N || i == 2 * N) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_count !== 4'd9 || out_data[W-1:0] !== W'(i - N + 1)) begin
          n_err++;
          $display("FAIL b2b_vector_at_word%0d: got v=%b c=%0d slot0=%0d want v=1 c=9 slot0=%0d",
                   i, out_valid, out_count, out_data[W-1:0], i - N + 1);
        end
      end
    end
    in_data = 4'h5;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_count !== 4'd1 || out_data !== 36'h000000005 || out_sum !== 8'd5) begin
      n_err++;
      $display("FAIL b2b_single_last: got v=%b d=%h s=%0d c=%0d want v=1 d=000000005 s=5 c=1",
               out_valid, out_data, out_sum, out_count);
    end
    drain();
  endtask

  task automatic test_backpressure_reset();
    logic [W-1:0] words [N];
    words = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5};
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_data = 4'hA;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 36'h562951413 || out_sum !== 8'd36 ||
          out_count !== 4'd9 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_cycle%0d: got v=%b d=%h s=%0d c=%0d r=%b want v=1 d=562951413 s=36 c=9 r=0",
                 c, out_valid, out_data, out_sum, out_count, in_ready);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sum !== '0 || out_count !== '0) begin
      n_err++;
      $display("FAIL bp_reset_outputs: got v=%b d=%h s=%0d c=%0d want all 0",
               out_valid, out_data, out_sum, out_count);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_after_reset: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 4'h7;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 36'h000000007 || out_count !== 4'd1) begin
      n_err++;
      $display("FAIL bp_restart_slot0: got v=%b d=%h c=%0d want v=1 d=000000007 c=1",
               out_valid, out_data, out_count);
    end
    drain();
  endtask

  task automatic test_random();
    logic [15:0] lfsr;
    int          accepted;
    int          cycles;
    int          in0;
    int          out0;
    lfsr     = 16'hACE1;
    accepted = 0;
    cycles   = 0;
    in0      = words_in;
    out0     = words_out;
    while (accepted < 10000 && cycles < 60000) begin
      lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      in_data   = lfsr[3:0];
      in_valid  = (lfsr[6:5] != 2'b00);
      in_last   = (lfsr[9:7] == 3'b000);
      out_ready = (lfsr[12:10] > 3'd2);
      @(negedge clk);
      if (in_valid && (!m_hold || out_ready)) accepted++;
      @(posedge clk); #1;
      cycles++;
    end
    n_cmp++;
    if (accepted < 10000) begin
      n_err++;
      $display("FAIL rand_budget: got %0d words want 10000", accepted);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (m_cnt != 0 && !m_hold) begin
      in_valid = 1'b1;
      in_data  = 4'h1;
      in_last  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    drain();
    n_cmp++;
    if ((words_out - out0) !== (words_in - in0)) begin
      n_err++;
      $display("FAIL rand_word_count: got %0d out want %0d in", words_out - out0, words_in - in0);
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_max_value();
    test_back_to_back();
    test_backpressure_reset();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
